// File: rtl/acorn_init128.sv
// ACORN-128 v3 initialization: loads key/IV, runs 1792 init steps from a zero state, holds the result.
// Define ACORN_INIT_UNROLL2_EN to run two chained steps per cycle (896-cycle latency).
module acorn_init128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  output logic         busy,
  output logic         done,
  output logic         state_valid,
  output logic [292:0] state_out,
  output logic [10:0]  step_count
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_t;

  localparam logic [10:0] LAST_STEP = 11'd1792;
`ifdef ACORN_INIT_UNROLL2_EN
  localparam logic [10:0] STEP_INC = 11'd2;
`else
  localparam logic [10:0] STEP_INC = 11'd1;
`endif

  fsm_t         fsm;
  logic [127:0] key_q;
  logic [127:0] iv_q;
  logic [292:0] s_next;
  logic [10:0]  count_next;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Message bit for step i: key, then IV, then a flipped K_0, then the key repeated.
  function automatic logic msg_bit(input logic [10:0] i, input logic [127:0] k,
                                   input logic [127:0] v);
    if (i < 11'd128)       return k[i[6:0]];
    else if (i < 11'd256)  return v[i[6:0]];
    else if (i == 11'd256) return ~k[0];
    else                   return k[i[6:0]];
  endfunction

  // One init step with ca = cb = 1; the feedback taps are applied in order before ks/f.
  function automatic logic [292:0] acorn_step(input logic [292:0] s_in, input logic m);
    logic [292:0] s;
    logic         ks;
    logic         f;
    s = s_in;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ s[196] ^ ks;
    return {f ^ m, s[292:1]};
  endfunction

  always_comb begin
    s_next     = acorn_step(state_out, msg_bit(step_count, key_q, iv_q));
`ifdef ACORN_INIT_UNROLL2_EN
    s_next     = acorn_step(s_next, msg_bit(step_count + 11'd1, key_q, iv_q));
`endif
    count_next = step_count + STEP_INC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm         <= IDLE;
      key_q       <= '0;
      iv_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      state_valid <= 1'b0;
      state_out   <= '0;
      step_count  <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE, HOLD: begin
          if (start) begin
            key_q       <= key_in;
            iv_q        <= iv_in;
            state_out   <= '0;
            step_count  <= '0;
            state_valid <= 1'b0;
            busy        <= 1'b1;
            fsm         <= RUN;
          end
        end
        RUN: begin
          state_out  <= s_next;
          step_count <= count_next;
          if (count_next == LAST_STEP) begin
            fsm         <= HOLD;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_valid <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acorn_init128.sv
// Self-checking bench for acorn_init128 against an array-based ACORN-128 init model.
module tb_acorn_init128;

`ifdef ACORN_INIT_UNROLL2_EN
  localparam int LAT = 896;
  localparam int INC = 2;
`else
  localparam int LAT = 1792;
  localparam int INC = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] iv_in = '0;
  logic         busy;
  logic         done;
  logic         state_valid;
  logic [292:0] state_out;
  logic [10:0]  step_count;

  int checks = 0;
  int errors = 0;

  acorn_init128 dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .iv_in(iv_in),
    .busy(busy), .done(done), .state_valid(state_valid),
    .state_out(state_out), .step_count(step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [292:0] obs, input logic [292:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the init sequence over a plain bit array, message bits precomputed.
  function automatic logic [292:0] ref_init(input logic [127:0] k, input logic [127:0] v);
    bit s[293];
    bit m[1792];
    bit ks, f, mj, cf;
    logic [292:0] r;
    for (int j = 0; j < 293; j++) s[j] = 1'b0;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)       m[i] = k[i];
      else if (i < 256)  m[i] = v[i - 128];
      else if (i == 256) m[i] = !k[0];
      else               m[i] = k[i % 128];
    end
    for (int i = 0; i < 1792; i++) begin
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66]  ^ s[61];
      s[61]  = s[61]  ^ s[23]  ^ s[0];
      mj = (s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]);
      cf = s[230] ? s[111] : s[66];
      ks = s[12] ^ s[154] ^ mj ^ cf;
      mj = (s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]);
      f  = s[0] ^ !s[107] ^ mj ^ s[196] ^ ks;
      for (int j = 0; j < 292; j++) s[j] = s[j + 1];
      s[292] = f ^ m[i];
    end
    for (int j = 0; j < 293; j++) r[j] = s[j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] k, input logic [127:0] v);
    key_in = k;
    iv_in  = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 4000) begin
      tick();
      n++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic wait_count(input string tag, input int target, output int n);
    n = 0;
    while (n < 4000 && int'(step_count) != target) begin
      tick();
      n++;
    end
    check(tag, 293'(int'(step_count) == target), 293'(1));
  endtask

  task automatic check_hold(input string tag, input logic [292:0] exp);
    check({tag, "_state"}, state_out, exp);
    check({tag, "_valid"}, 293'(state_valid), 293'(1));
    check({tag, "_busy"}, 293'(busy), 293'(0));
    check({tag, "_count"}, 293'(step_count), 293'(1792));
  endtask

  initial begin
    logic [127:0] ka, kb, va, vb, kc, vc, kd, ke;
    logic [292:0] exp0, held;
    int n, w, r;

    // Reset state
    rst = 1'b0;
    tick(); tick();
    check("rst_busy", 293'(busy), 293'(0));
    check("rst_done", 293'(done), 293'(0));
    check("rst_valid", 293'(state_valid), 293'(0));
    check("rst_state", state_out, '0);
    check("rst_count", 293'(step_count), 293'(0));
    #2 rst = 1'b1;
    tick();

    // Zero key/IV: latency, first-step count, result, and 100 cycles of hold
    exp0 = ref_init('0, '0);
    pulse_start('0, '0);
    check("zero_busy", 293'(busy), 293'(1));
    check("zero_count0", 293'(step_count), 293'(0));
    tick();
    check("zero_count1", 293'(step_count), 293'(INC));
    check("zero_nodone", 293'(done), 293'(0));
    wait_done(n);
    check("zero_latency", 293'(n + 1), 293'(LAT));
    check_hold("zero", exp0);
    held = state_out;
    tick();
    check("zero_done_pulse", 293'(done), 293'(0));
    for (int c = 0; c < 100; c++) begin
      if (!state_valid || state_out !== held) begin
        check("zero_hold", {state_out[291:0], state_valid}, {held[291:0], 1'b1});
        break;
      end
      tick();
    end
    check("zero_hold_end", {state_out[291:0], state_valid}, {held[291:0], 1'b1});

    // Counting key/IV vector
    ka = 128'h000102030405060708090a0b0c0d0e0f;
    va = 128'hf0e0d0c0b0a090807060504030201000;
    pulse_start(ka, va);
    wait_done(n);
    check("vec_latency", 293'(n), 293'(LAT));
    check_hold("vec", ref_init(ka, va));

    // Random vectors
    for (int t = 0; t < 2; t++) begin
      kb = {$urandom, $urandom, $urandom, $urandom};
      vb = {$urandom, $urandom, $urandom, $urandom};
      pulse_start(kb, vb);
      wait_done(n);
      check("rand_latency", 293'(n), 293'(LAT));
      check_hold("rand", ref_init(kb, vb));
    end

    // start during RUN is ignored
    kc = {$urandom, $urandom, $urandom, $urandom};
    vc = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(kc, vc);
    wait_count("ign_reach500", 500, w);
    pulse_start(~kc, ~vc);
    check("ign_busy", 293'(busy), 293'(1));
    wait_done(r);
    check("ign_latency", 293'(w + 1 + r), 293'(LAT));
    check_hold("ign", ref_init(kc, vc));

    // Asynchronous reset mid-run, then a clean run
    kd = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(kd, vc);
    wait_count("rstmid_reach1000", 1000, w);
    #2 rst = 1'b0;
    #1;
    check("rstmid_busy", 293'(busy), 293'(0));
    check("rstmid_done", 293'(done), 293'(0));
    check("rstmid_valid", 293'(state_valid), 293'(0));
    check("rstmid_state", state_out, '0);
    check("rstmid_count", 293'(step_count), 293'(0));
    tick();
    #2 rst = 1'b1;
    tick(); tick(); tick();
    check("rstmid_idle_count", 293'(step_count), 293'(0));
    check("rstmid_idle_busy", 293'(busy), 293'(0));
    pulse_start(kd, vc);
    wait_done(n);
    check("rstmid_latency", 293'(n), 293'(LAT));
    check_hold("rstmid", ref_init(kd, vc));

    // Restart from HOLD with a new IV
    vb = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(kd, vb);
    check("hold_restart_valid", 293'(state_valid), 293'(0));
    check("hold_restart_busy", 293'(busy), 293'(1));
    wait_done(n);
    check("hold_restart_latency", 293'(n), 293'(LAT));
    check_hold("hold_restart", ref_init(kd, vb));

    // Back-to-back: start on the done cycle
    ke = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(ka, vb);
    wait_done(n);
    check("b2b_first_latency", 293'(n), 293'(LAT));
    check("b2b_first_state", state_out, ref_init(ka, vb));
    pulse_start(ke, va);
    check("b2b_busy", 293'(busy), 293'(1));
    check("b2b_valid", 293'(state_valid), 293'(0));
    check("b2b_count", 293'(step_count), 293'(0));
    wait_done(n);
    check("b2b_second_latency", 293'(n), 293'(LAT));
    check_hold("b2b_second", ref_init(ke, va));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acorn_init128.md
# acorn_init128

Initialization stage of the ACORN-128 datapath, directly upstream of encryption. Loads a 128-bit key and 128-bit IV, runs the 1792 ACORN-128 v3 initialization steps from an all-zero 293-bit state, then holds the initialized state. It raises a level-valid flag that drives the encryption stage's `start_epi` and `state_in`.

## Interface
- No parameters. Step rate is set by the macro in Configuration.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 clears all state.
- start  input  1  one-cycle request; sampled only in IDLE or HOLD.
- key_in  input  128  key K, bit i = K_i; captured on accepted start.
- iv_in  input  128  IV, bit i = IV_i; captured on accepted start.
- busy  output  1  high while RUN.
- done  output  1  one-cycle pulse on the RUN→HOLD transition.
- state_valid  output  1  high in HOLD; drives encryption `start_epi`.
- state_out  output  293  register S[292:0]; drives encryption `state_in`.
- step_count  output  11  steps completed in the current run (0..1792).

## Operation
- FSM states: IDLE, RUN, HOLD. Reset → IDLE with all outputs 0.
- IDLE/HOLD + start=1 → RUN:
  - capture key_in/iv_in into internal registers;
  - S ← 0, step_count ← 0, state_valid ← 0.
- RUN: each cycle applies the step(s) to S with index i = step_count, then increments step_count.
- Run completes when step_count reaches 1792 → HOLD: done=1 for that cycle, state_valid=1, S frozen.
- Message bit m_i:
  - K_i for i in 0..127;
  - IV_(i-128) for i in 128..255;
  - K_0 XOR 1 for i = 256;
  - K_(i mod 128) for i in 257..1791.
- Control bits: ca_i = cb_i = 1 for every init step.
- One step (ACORN-128 v3), combinational, on S:
  - Apply these in order: S289 ^= S235^S230; S230 ^= S196^S193; S193 ^= S160^S154; S154 ^= S111^S107; S107 ^= S66^S61; S61 ^= S23^S0.
  - Using the updated S: ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66).
  - Using the updated S: f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca&S196) ^ (cb&ks).
  - Shift: S_j ← S_(j+1) for j = 0..291; S292 ← f ^ m_i.
- start while RUN: ignored. No restart, no captured-input change.
- start in HOLD: restarts with the new key/IV; state_valid drops the next cycle.
- Key and IV registers are internal only and are never driven onto outputs.

## Timing
- Accepted start at edge T:
  - busy=1 from T+1;
  - step_count=1 after edge T+1;
  - done=1 and state_valid=1 after edge T+1792 (default build);
  - busy=0 at that same edge.
- done: a single-cycle pulse. state_valid: a level held until the next accepted start or reset.
- state_out changes only during RUN. Intermediate values are visible but are meaningful only when state_valid=1.
- step_count is held at 1792 in HOLD and cleared on the next accepted start.
- Reset asserted mid-run:
  - immediately: busy=0, done=0, state_valid=0, state_out=0, step_count=0; FSM → IDLE;
  - after deassertion, no steps run until a new start.
- start coincident with reset deassertion edge: ignored; takes effect only on a clean sampled edge.

## Configuration
- ACORN_INIT_UNROLL2_EN defined:
  - two chained steps per cycle (indices i and i+1);
  - step_count advances by 2; HOLD reached 896 cycles after start.
- Undefined: one step per cycle, 1792-cycle latency.
- Final state_out is bit-identical in both builds; step_count only takes even values when the macro is defined.

## Test plan
- K=0, IV=0, start → done pulse exactly 1792 cycles later (896 with the macro); state_out equals the C reference model; state_valid stays 1 for 100 further cycles.
- K=0x000102…0F, IV=0xF0E0…00 → state_out matches the model. Repeat both vectors with and without ACORN_INIT_UNROLL2_EN; results identical.
- start pulsed at step_count=500 with a different key → ignored; final state equals the first key's result.
- rst=0 at step_count=1000 → all outputs 0 asynchronously. Release, start again → correct result, no residue from the aborted run.
- In HOLD, start with a new IV → state_valid=0 next cycle; new correct state after full latency.
- Back-to-back: start on the same cycle as done → the current run completes, then the new run begins immediately.
